// File: rtl/apb_pkg.sv
// Shared APB definitions for the register slave: bus widths, FSM state and latched request payload.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_ADDR_W = 32;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic                  in_range;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // Register-index width for a power-of-two register count.
  function automatic int unsigned idx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_fsm.sv
// APB completer protocol FSM: setup/access sequencing, wait-state counter, pready and commit pulses.
// Optional error response (pslverr) is built when APB_REG_SLAVE_PSLVERR_EN is defined.
module apb_slv_fsm
  import apb_pkg::*;
#(
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             psel,
  input  logic                             pen,
  input  logic                             pwrite,
  input  logic [APB_ADDR_W-1:0]            paddr,
  input  logic [APB_DATA_W-1:0]            pwdata,
  output logic                             pready,
`ifdef APB_REG_SLAVE_PSLVERR_EN
  output logic                             pslverr,
`endif
  output logic [idx_width(NUM_REGS)-1:0]   idx_q,
  output logic [APB_DATA_W-1:0]            wdata_q,
  output logic [idx_width(NUM_REGS)-1:0]   load_idx_c,
  output logic                             load_rng_c,
  output logic                             load_rd_c,
  output logic                             commit_wr_c,
  output logic                             commit_rd_c
);

  localparam int unsigned          IDX_W      = idx_width(NUM_REGS);
  localparam int unsigned          CNT_W      = 4;
  localparam logic [CNT_W-1:0]     WAIT_INIT  = CNT_W'(WAIT_CYCLES);
  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT = APB_ADDR_W'(NUM_REGS * 4);

  apb_state_t       state;
  logic [CNT_W-1:0] cnt;
  apb_req_t         req_q;

  logic [IDX_W-1:0] cur_idx_c;
  logic             cur_rng_c;
  logic             setup_c;
  logic             access_c;
  logic             complete_c;
  logic             rise_c;

  assign wdata_q = req_q.wdata;

  // Decode and handshake qualifiers; in IDLE the read mux looks at the live address.
  always_comb begin
    cur_idx_c   = paddr[2 +: IDX_W];
    cur_rng_c   = (paddr < ADDR_LIMIT);
    setup_c     = (state == IDLE) && psel && !pen;
    access_c    = (state == ACCESS) && psel && pen;
    complete_c  = access_c && pready;
    rise_c      = access_c && !pready && (cnt == CNT_W'(1));
    load_rd_c   = (setup_c && !pwrite && (WAIT_CYCLES == 0)) || (rise_c && !req_q.write);
    load_idx_c  = (state == IDLE) ? cur_idx_c : idx_q;
    load_rng_c  = (state == IDLE) ? cur_rng_c : req_q.in_range;
    commit_wr_c = complete_c && req_q.write && req_q.in_range && !RO_MASK[idx_q];
    commit_rd_c = complete_c && !req_q.write && req_q.in_range;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      pready <= 1'b0;
      cnt    <= '0;
      idx_q  <= '0;
      req_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup_c) begin
            state <= ACCESS;
            idx_q <= cur_idx_c;
            req_q <= '{write: pwrite, in_range: cur_rng_c, wdata: pwdata};
            if (WAIT_CYCLES == 0) pready <= 1'b1;
            else                  cnt    <= WAIT_INIT;
          end
        end
        ACCESS: begin
          if (!psel) begin
            // Initiator abandoned the transfer: nothing is committed.
            state  <= IDLE;
            pready <= 1'b0;
            cnt    <= '0;
          end else if (pen) begin
            if (pready) begin
              state  <= IDLE;
              pready <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) pready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_REG_SLAVE_PSLVERR_EN
  logic err_c;
  logic err_q;

  assign err_c = !cur_rng_c || (pwrite && RO_MASK[cur_idx_c]);

  // Error flag travels with pready: raised when pready rises, dropped with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q   <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      if (setup_c) err_q <= err_c;
      if (setup_c && (WAIT_CYCLES == 0))                 pslverr <= err_c;
      else if (rise_c)                                   pslverr <= err_q;
      else if ((state == ACCESS) && (!psel || complete_c)) pslverr <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave: RW/RO register bank, read mux and access strobes around apb_slv_fsm.
// Define APB_REG_SLAVE_PSLVERR_EN to add the pslverr error response port.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           psel,
  input  logic                           pen,
  input  logic                           pwrite,
  input  logic [APB_ADDR_W-1:0]          paddr,
  input  logic [APB_DATA_W-1:0]          pwdata,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pready,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*APB_DATA_W-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_stb,
  output logic [NUM_REGS-1:0]            rd_stb
`ifdef APB_REG_SLAVE_PSLVERR_EN
  ,
  output logic                           pslverr
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_REGS);

  logic [NUM_REGS-1:0][APB_DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][APB_DATA_W-1:0] hw_arr;
  logic [IDX_W-1:0]                    idx_q;
  logic [IDX_W-1:0]                    load_idx_c;
  logic [APB_DATA_W-1:0]               wdata_q;
  logic [APB_DATA_W-1:0]               rd_mux_c;
  logic                                load_rng_c;
  logic                                load_rd_c;
  logic                                commit_wr_c;
  logic                                commit_rd_c;

  assign hw_arr  = hw_in;
  assign reg_out = regs_q;

  apb_slv_fsm #(
    .NUM_REGS    (NUM_REGS),
    .WAIT_CYCLES (WAIT_CYCLES),
    .RO_MASK     (RO_MASK)
  ) u_fsm (
    .clk         (clk),
    .rstn        (rstn),
    .psel        (psel),
    .pen         (pen),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
`ifdef APB_REG_SLAVE_PSLVERR_EN
    .pslverr     (pslverr),
`endif
    .idx_q       (idx_q),
    .wdata_q     (wdata_q),
    .load_idx_c  (load_idx_c),
    .load_rng_c  (load_rng_c),
    .load_rd_c   (load_rd_c),
    .commit_wr_c (commit_wr_c),
    .commit_rd_c (commit_rd_c)
  );

  // Read source: hardware input for RO registers, bank contents otherwise, zero when unmapped.
  always_comb begin
    rd_mux_c = '0;
    if (load_rng_c) rd_mux_c = RO_MASK[load_idx_c] ? hw_arr[load_idx_c] : regs_q[load_idx_c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q <= '0;
      prdata <= '0;
      wr_stb <= '0;
      rd_stb <= '0;
    end else begin
      wr_stb <= '0;
      rd_stb <= '0;
      if (load_rd_c) prdata <= rd_mux_c;
      if (commit_wr_c) begin
        regs_q[idx_q] <= wdata_q;
        wr_stb[idx_q] <= 1'b1;
      end
      if (commit_rd_c) rd_stb[idx_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench for apb_reg_slave: dut 0 has no wait states, dut 1 has three; both map reg 7 read-only.
module tb_apb_reg_slave;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    bit          chk_rd;
    logic [7:0]  wstb;
    logic [7:0]  rstb;
    int          waits;
    bit          err;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic [1:0]   psel_v;
  logic         pen;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic [255:0] hw_in;

  logic [31:0]  prdata_a, prdata_b;
  logic         pready_a, pready_b;
  logic [255:0] reg_out_a, reg_out_b;
  logic [7:0]   wr_stb_a, wr_stb_b, rd_stb_a, rd_stb_b;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  logic         pslverr_a, pslverr_b;
  logic [1:0]   pslverr_v;
  assign pslverr_v = {pslverr_b, pslverr_a};
`endif

  logic [1:0]         pready_v;
  logic [1:0][31:0]   prdata_v;
  logic [1:0][255:0]  reg_out_v;
  logic [1:0][7:0]    wr_stb_v, rd_stb_v;
  assign pready_v  = {pready_b, pready_a};
  assign prdata_v  = {prdata_b, prdata_a};
  assign reg_out_v = {reg_out_b, reg_out_a};
  assign wr_stb_v  = {wr_stb_b, wr_stb_a};
  assign rd_stb_v  = {rd_stb_b, rd_stb_a};

  logic [255:0] model [2];
  exp_t         sb[$];
  int           checks;
  int           failures;

  apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h80)) u_dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel_v[0]),
    .pen     (pen),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata_a),
    .pready  (pready_a),
    .reg_out (reg_out_a),
    .hw_in   (hw_in),
    .wr_stb  (wr_stb_a),
    .rd_stb  (rd_stb_a)
`ifdef APB_REG_SLAVE_PSLVERR_EN
    ,
    .pslverr (pslverr_a)
`endif
  );

  apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h80)) u_dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .psel    (psel_v[1]),
    .pen     (pen),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata_b),
    .pready  (pready_b),
    .reg_out (reg_out_b),
    .hw_in   (hw_in),
    .wr_stb  (wr_stb_b),
    .rd_stb  (rd_stb_b)
`ifdef APB_REG_SLAVE_PSLVERR_EN
    ,
    .pslverr (pslverr_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: strobes/reg_out every cycle, completion data against the scoreboard head.
  exp_t pend [2];
  bit   pv [2];
  int   wc [2];
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        pv[d] = 1'b0;
        wc[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("reg_out dut%0d", d), reg_out_v[d], model[d]);
        chk($sformatf("wr_stb dut%0d", d), 256'(wr_stb_v[d]), 256'(pv[d] ? pend[d].wstb : 8'h00));
        chk($sformatf("rd_stb dut%0d", d), 256'(rd_stb_v[d]), 256'(pv[d] ? pend[d].rstb : 8'h00));
        pv[d] = 1'b0;
        if (psel_v[d] && pen) begin
          if (!pready_v[d]) begin
            wc[d]++;
          end else begin
            if (sb.size() == 0 || sb[0].dut != d) begin
              checks++;
              failures++;
              $display("FAIL unexpected_completion dut%0d: got pready 1 expected 0 at %0t", d, $time);
            end else begin
              e = sb.pop_front();
              chk($sformatf("wait_cycles dut%0d", d), 256'(wc[d]), 256'(e.waits));
              if (e.chk_rd) chk($sformatf("prdata dut%0d", d), 256'(prdata_v[d]), 256'(e.rdata));
`ifdef APB_REG_SLAVE_PSLVERR_EN
              chk($sformatf("pslverr dut%0d", d), 256'(pslverr_v[d]), 256'(e.err));
`endif
              pend[d] = e;
              pv[d]   = 1'b1;
            end
            wc[d] = 0;
          end
        end else begin
          wc[d] = 0;
        end
      end
    end
  end

  // Issue one transfer and push its expected response; returns #1 after the completion edge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input logic [7:0] wstb, input logic [7:0] rstb,
                      input bit err);
    exp_t e;
    bit   done;
    e.dut = d; e.rdata = exp_rd; e.chk_rd = !wr; e.wstb = wstb; e.rstb = rstb;
    e.waits = (d == 0) ? 0 : 3; e.err = err;
    sb.push_back(e);
    psel_v    = '0;
    psel_v[d] = 1'b1;
    pen = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    pen  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (pready_v[d]) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout dut%0d addr %0h: got pready 0 expected 1", d, addr);
      sb.delete();
    end
    @(posedge clk); #1;
    if (done) for (int i = 0; i < 8; i++) if (wstb[i]) model[d][32*i +: 32] = data;
  endtask

  task automatic idle();
    psel_v = '0;
    pen    = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input int d);
    chk($sformatf("rst_prdata dut%0d", d), 256'(prdata_v[d]), '0);
    chk($sformatf("rst_pready dut%0d", d), 256'(pready_v[d]), '0);
    chk($sformatf("rst_reg_out dut%0d", d), reg_out_v[d], '0);
    chk($sformatf("rst_wr_stb dut%0d", d), 256'(wr_stb_v[d]), '0);
    chk($sformatf("rst_rd_stb dut%0d", d), 256'(rd_stb_v[d]), '0);
`ifdef APB_REG_SLAVE_PSLVERR_EN
    chk($sformatf("rst_pslverr dut%0d", d), 256'(pslverr_v[d]), '0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; psel_v = '0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model[0] = '0; model[1] = '0;
    for (int i = 0; i < 8; i++) hw_in[32*i +: 32] = 32'h0BAD_0000 | 32'(i);
    hw_in[255:224] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait slave: RW, RO, unmapped, ignored byte offset, back-to-back.
    xfer(0, 1, 32'h04, 32'hA5A5_1234, 32'h0, 8'h02, 8'h00, 1'b0); idle();
    xfer(0, 0, 32'h04, 32'h0, 32'hA5A5_1234, 8'h00, 8'h02, 1'b0); idle();
    xfer(0, 0, 32'h1C, 32'h0, 32'hDEAD_BEEF, 8'h00, 8'h80, 1'b0); idle();
    xfer(0, 1, 32'h1C, 32'h1, 32'h0, 8'h00, 8'h00, 1'b1); idle();
    xfer(0, 0, 32'h1C, 32'h0, 32'hDEAD_BEEF, 8'h00, 8'h80, 1'b0); idle();
    xfer(0, 0, 32'h40, 32'h0, 32'h0, 8'h00, 8'h00, 1'b1); idle();
    xfer(0, 1, 32'h40, 32'hFFFF_FFFF, 32'h0, 8'h00, 8'h00, 1'b1); idle();
    xfer(0, 1, 32'h0B, 32'h3333_0003, 32'h0, 8'h04, 8'h00, 1'b0); idle();
    xfer(0, 0, 32'h08, 32'h0, 32'h3333_0003, 8'h00, 8'h04, 1'b0); idle();
    xfer(0, 1, 32'h00, 32'h1234_5678, 32'h0, 8'h01, 8'h00, 1'b0);
    xfer(0, 0, 32'h00, 32'h0, 32'h1234_5678, 8'h00, 8'h01, 1'b0); idle();

    // Access phase with no preceding setup must be ignored.
    psel_v = 2'b01; pen = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pen_no_setup pready", 256'(pready_a), '0);
    idle();

    // Three-wait slave, then an abort after two access cycles.
    xfer(1, 1, 32'h08, 32'hCAFE_F00D, 32'h0, 8'h04, 8'h00, 1'b0); idle();
    xfer(1, 0, 32'h08, 32'h0, 32'hCAFE_F00D, 8'h00, 8'h04, 1'b0); idle();
    psel_v = 2'b10; pen = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1111_1111;
    @(posedge clk); #1;
    pen = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel_v = '0; pen = 1'b0;
    @(posedge clk); #1;
    chk("abort pready", 256'(pready_b), '0);
    xfer(1, 0, 32'h10, 32'h0, 32'h0, 8'h00, 8'h10, 1'b0); idle();
    xfer(1, 1, 32'h1C, 32'h5, 32'h0, 8'h00, 8'h00, 1'b1); idle();

    // Reset asserted while a write waits in its access phase.
    xfer(0, 0, 32'h04, 32'h0, 32'hA5A5_1234, 8'h00, 8'h02, 1'b0); idle();
    psel_v = 2'b01; pen = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h0;
    @(posedge clk); #1;
    pen = 1'b1;
    chk("pre_reset pready", 256'(pready_a), 256'(1));
    #1;
    rstn = 1'b0;
    model[0] = '0; model[1] = '0;
    #1;
    chk_zero(0);
    chk_zero(1);
    psel_v = '0; pen = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xfer(0, 0, 32'h04, 32'h0, 32'h0, 8'h00, 8'h02, 1'b0); idle();
    xfer(1, 0, 32'h08, 32'h0, 32'h0, 8'h00, 8'h04, 1'b0); idle();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 256'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
